// File: rtl/mapeo_distancia_param.sv
`default_nettype none
// ============================================================================
// Module      : mapeo_distancia_param
// Description : Linear, clamped, round-half-up mapping of a sensor distance
//               onto 0..2^OUT_W-1. Uses a valid/ready handshake and a
//               restoring shift-subtract divider.
//               Optional MAPEO_PROMEDIO_EN: 4-deep moving average of results.
// Revision    : 1.0 - initial release
// ============================================================================
module mapeo_distancia_param #(
   parameter int IN_W     = 9,
   parameter int OUT_W    = 8,
   parameter int DIST_MIN = 5,
   parameter int DIST_MAX = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IN_W-1:0]  distancia,
   input  logic             entrada_valida,
   output logic             entrada_lista,
   output logic [OUT_W-1:0] distancia_mapeada,
   output logic             salida_valida,
   input  logic             salida_lista,
   output logic             fuera_rango
);

   localparam int SPAN    = DIST_MAX - DIST_MIN;
   localparam int NUM_W   = IN_W + OUT_W + 1;
   localparam int OUT_MAX = (1 << OUT_W) - 1;
   localparam int CNT_W   = 5;

   localparam logic [IN_W-1:0]  c_dist_min = IN_W'(DIST_MIN);
   localparam logic [IN_W-1:0]  c_dist_max = IN_W'(DIST_MAX);
   localparam logic [IN_W:0]    c_span     = (IN_W+1)'(SPAN);
   localparam logic [NUM_W-1:0] c_out_max  = NUM_W'(OUT_MAX);
   localparam logic [NUM_W-1:0] c_half     = NUM_W'(SPAN / 2);
   localparam logic [CNT_W-1:0] c_cnt_ini  = CNT_W'(NUM_W - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_SAL  = 2'd3
   } state_t;

   state_t             r_state;
   logic [IN_W-1:0]    r_dc;
   logic               r_rango;
   logic [NUM_W-1:0]   r_num;
   logic [IN_W-1:0]    r_rem;
   logic [CNT_W-1:0]   r_cnt;
   logic [OUT_W-1:0]   r_mapeada;
   logic               r_valida;
   logic               r_fuera;
   logic               r_lista;

   logic               w_rango;
   logic [IN_W:0]      w_rem_sh;
   logic               w_ge;
   logic [NUM_W-1:0]   w_num_nx;
   logic [OUT_W-1:0]   w_q;
   logic [OUT_W-1:0]   w_result;

   assign w_rango  = (distancia < c_dist_min) || (distancia > c_dist_max);

   // r_num shifts the dividend out at the top while quotient bits enter at the bottom
   assign w_rem_sh = {r_rem, r_num[NUM_W-1]};
   assign w_ge     = (w_rem_sh >= c_span);
   assign w_num_nx = {r_num[NUM_W-2:0], w_ge};
   assign w_q      = w_num_nx[OUT_W-1:0];

`ifdef MAPEO_PROMEDIO_EN
   logic [OUT_W-1:0]   r_h0, r_h1, r_h2;
   logic               r_primero;
   logic [OUT_W-1:0]   w_h0, w_h1, w_h2;
   logic [OUT_W+1:0]   w_suma;

   // The first sample after reset sees a history filled with itself
   assign w_h0     = r_primero ? w_q : r_h0;
   assign w_h1     = r_primero ? w_q : r_h1;
   assign w_h2     = r_primero ? w_q : r_h2;
   assign w_suma   = {2'b00, w_q} + {2'b00, w_h0} + {2'b00, w_h1} + {2'b00, w_h2};
   assign w_result = OUT_W'(w_suma >> 2);
`else
   assign w_result = w_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_dc      <= '0;
         r_rango   <= 1'b0;
         r_num     <= '0;
         r_rem     <= '0;
         r_cnt     <= '0;
         r_mapeada <= '0;
         r_valida  <= 1'b0;
         r_fuera   <= 1'b0;
         r_lista   <= 1'b1;
`ifdef MAPEO_PROMEDIO_EN
         r_h0      <= '0;
         r_h1      <= '0;
         r_h2      <= '0;
         r_primero <= 1'b1;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (entrada_valida && r_lista) begin
                  if (distancia < c_dist_min)
                     r_dc <= c_dist_min;
                  else if (distancia > c_dist_max)
                     r_dc <= c_dist_max;
                  else
                     r_dc <= distancia;
                  r_rango <= w_rango;
                  r_lista <= 1'b0;
                  r_state <= S_MUL;
               end
            end
            S_MUL: begin
               r_num   <= NUM_W'(r_dc - c_dist_min) * c_out_max + c_half;
               r_rem   <= '0;
               r_cnt   <= c_cnt_ini;
               r_state <= S_DIV;
            end
            S_DIV: begin
               r_num <= w_num_nx;
               r_rem <= w_ge ? IN_W'(w_rem_sh - c_span) : w_rem_sh[IN_W-1:0];
               r_cnt <= r_cnt - CNT_W'(1);
               // Last quotient bit is resolved here, so the result is loaded on the same edge
               if (r_cnt == '0) begin
                  r_mapeada <= w_result;
                  r_fuera   <= r_rango;
                  r_valida  <= 1'b1;
                  r_state   <= S_SAL;
`ifdef MAPEO_PROMEDIO_EN
                  r_h2      <= w_h1;
                  r_h1      <= w_h0;
                  r_h0      <= w_q;
                  r_primero <= 1'b0;
`endif
               end
            end
            S_SAL: begin
               if (salida_lista) begin
                  r_valida <= 1'b0;
                  r_lista  <= 1'b1;
                  r_state  <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_lista <= 1'b1;
            end
         endcase
      end
   end

   assign entrada_lista     = r_lista;
   assign distancia_mapeada = r_mapeada;
   assign salida_valida     = r_valida;
   assign fuera_rango       = r_fuera;

endmodule
`default_nettype wire
